// File: rtl/decodeur_iq.sv
// Half-sine O-QPSK/MSK I/Q demodulator: integrates the active channel over each chip
// window, slices the sum to a sign and undoes the coder's differential sign rule.
module decodeur_iq #(
    parameter int unsigned SAMPLES_PER_CHIP = 25,
    parameter int unsigned DATA_W           = 4,
    parameter int unsigned ACC_W            = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] IBB,
    input  logic signed [DATA_W-1:0] QBB,
    output logic                     b_out,
    output logic                     b_valid,
    output logic                     ready
);

    localparam int unsigned CNT_W = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
    localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SAMPLES_PER_CHIP - 1);

    typedef enum logic [1:0] {IDLE, FIRST, RUN} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     sI_q, sQ_q, prev_q, k_odd_q;
    logic                     b_out_q, b_valid_q, ready_q;

    logic signed [ACC_W-1:0]  i_ext, q_ext, smp_d, acc_d;
    logic                     new_s_d, s_act, bit_d, last_d;

    always_comb begin
        i_ext   = {{(ACC_W-DATA_W){IBB[DATA_W-1]}}, IBB};
        q_ext   = {{(ACC_W-DATA_W){QBB[DATA_W-1]}}, QBB};
        // Window 0 and odd windows integrate I, even windows (k >= 2) integrate Q.
        smp_d   = (state_q == RUN && !k_odd_q) ? q_ext : i_ext;
        acc_d   = acc_q + smp_d;
        new_s_d = ~acc_d[ACC_W-1];
        s_act   = k_odd_q ? sI_q : sQ_q;
        bit_d   = prev_q ^ (new_s_d == s_act);
        last_d  = (cnt_q == LAST_SMP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sI_q      <= 1'b0;
            sQ_q      <= 1'b0;
            prev_q    <= 1'b0;
            k_odd_q   <= 1'b0;
            b_out_q   <= 1'b0;
            b_valid_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            b_valid_q <= 1'b0;
            if (start) begin
                // Start always wins, even over the last sample of a window.
                state_q <= FIRST;
                ready_q <= 1'b0;
                k_odd_q <= 1'b0;
                if (s_valid) begin
                    acc_q <= i_ext;
                    cnt_q <= CNT_W'(1);
                end else begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end
            end else if (state_q != IDLE && s_valid) begin
                if (last_d) begin
                    cnt_q     <= '0;
                    acc_q     <= '0;
                    b_valid_q <= 1'b1;
                    k_odd_q   <= ~k_odd_q;
                    if (state_q == FIRST) begin
                        sI_q    <= new_s_d;
                        sQ_q    <= 1'b1;
                        b_out_q <= new_s_d;
                        prev_q  <= new_s_d;
                        state_q <= RUN;
                    end else begin
                        if (k_odd_q) sI_q <= new_s_d;
                        else         sQ_q <= new_s_d;
                        b_out_q <= bit_d;
                        prev_q  <= bit_d;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= acc_d;
                end
            end
        end
    end

    assign b_out   = b_out_q;
    assign b_valid = b_valid_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_decodeur_iq.sv
// Bench for decodeur_iq: a behavioural IQ coder produces sample windows from bit
// patterns; the decoded bits, strobe timing and control behaviour are asserted.
module tb_decodeur_iq;

    localparam int SPC = 25;
    localparam logic signed [3:0] P7 = 4'sd7;
    localparam logic signed [3:0] N7 = -4'sd7;
    localparam logic signed [3:0] Z0 = 4'sd0;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic signed [3:0] IBB = '0;
    logic signed [3:0] QBB = '0;
    logic              b_out, b_valid, ready;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    always #10 clk = ~clk;

    decodeur_iq #(.SAMPLES_PER_CHIP(SPC), .DATA_W(4), .ACC_W(10)) dut (
        .clk(clk), .resetn(resetn), .start(start), .s_valid(s_valid),
        .IBB(IBB), .QBB(QBB), .b_out(b_out), .b_valid(b_valid), .ready(ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge, then return 1 time unit after it.
    task automatic drive(input logic st, input logic v, input logic signed [3:0] i,
                         input logic signed [3:0] q);
        start = st; s_valid = v; IBB = i; QBB = q;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0; s_valid = 1'b0;
    endtask

    function automatic logic signed [3:0] act_smp(input bit pos);
        int m;
        m = int'($urandom_range(7, 1));
        return pos ? 4'(m) : 4'(-m);
    endfunction

    function automatic logic signed [3:0] noise();
        return 4'($urandom_range(15, 0));
    endfunction

    // Window 0 from a start pulse with a constant I value.
    task automatic win0(input string tag, input logic signed [3:0] iv, input bit expb);
        for (int n = 0; n < SPC; n++) begin
            drive(n == 0, 1'b1, iv, noise());
            if (n == SPC - 1) begin
                check({tag, " b_valid"}, b_valid, 1);
                check({tag, " b_out"}, b_out, expb);
            end else if (n == 0 || n == SPC - 2) begin
                check({tag, " early b_valid"}, b_valid, 0);
            end
        end
        drive(1'b0, 1'b0, Z0, Z0);
        check({tag, " pulse width"}, b_valid, 0);
    endtask

    // Coder model: window 0 carries bit 0 as the I sign; from then on I and Q
    // alternate and a channel's sign flips exactly when consecutive bits are equal.
    task automatic run_stream(input string tag, input bit bits[16], input int nbits,
                              input int unsigned gap, input int partial);
        bit sg[2];
        int ch;
        int unsigned t_prev;
        logic signed [3:0] a, z;
        t_prev = 0;
        ch = 0;
        for (int k = 0; k < nbits; k++) begin
            if (k == 0) begin
                sg[0] = bits[0]; sg[1] = 1'b1; ch = 0;
            end else begin
                ch = (k % 2 == 1) ? 0 : 1;
                if (bits[k] == bits[k-1]) sg[ch] = ~sg[ch];
            end
            for (int n = 0; n < SPC; n++) begin
                a = act_smp(sg[ch]);
                z = noise();
                drive(k == 0 && n == 0, 1'b1, (ch == 0) ? a : z, (ch == 0) ? z : a);
                if (n == SPC - 1) begin
                    check({tag, " b_valid"}, b_valid, 1);
                    check({tag, " b_out"}, b_out, bits[k]);
                    if (k > 0) check({tag, " spacing"}, cyc - t_prev, SPC * (gap + 1));
                    t_prev = cyc;
                end else begin
                    check({tag, " no b_valid"}, b_valid, 0);
                end
                for (int g = 0; g < int'(gap); g++) begin
                    drive(1'b0, 1'b0, noise(), noise());
                    check({tag, " stall b_valid"}, b_valid, 0);
                end
            end
        end
        for (int n = 0; n < partial; n++) begin
            drive(1'b0, 1'b1, noise(), noise());
            check({tag, " partial b_valid"}, b_valid, 0);
        end
    endtask

    initial begin
        bit pat[16];
        bit fresh;
        @(posedge clk); #1;

        // Reset held for 5 cycles
        resetn = 1'b0;
        for (int n = 0; n < 5; n++) drive(1'b0, 1'b0, Z0, Z0);
        check("reset b_out", b_out, 0);
        check("reset b_valid", b_valid, 0);
        check("reset ready", ready, 1);
        resetn = 1'b1;
        drive(1'b0, 1'b1, P7, P7);
        check("idle ignores samples", b_valid, 0);
        check("idle ready", ready, 1);

        // Window 0 directed, then tie in window 1
        win0("w0 pos", P7, 1'b1);
        check("ready low after start", ready, 0);
        win0("w0 neg", N7, 1'b0);
        win0("tie w0", P7, 1'b1);
        for (int n = 0; n < SPC; n++) begin
            drive(1'b0, 1'b1, Z0, noise());
            if (n == SPC - 1) begin
                check("tie b_valid", b_valid, 1);
                check("tie b_out", b_out, 0);
            end
        end

        // Start coinciding with the 25th sample: no bit, start sample opens window 0
        win0("pre abort", P7, 1'b1);
        for (int n = 0; n < SPC - 1; n++) drive(n == 0, 1'b1, N7, Z0);
        drive(1'b1, 1'b1, P7, Z0);
        check("abort at last b_valid", b_valid, 0);
        check("abort at last b_out held", b_out, 1);
        for (int n = 1; n < SPC; n++) begin
            drive(1'b0, 1'b1, P7, Z0);
            if (n == SPC - 1) begin
                check("after abort b_valid", b_valid, 1);
                check("after abort b_out", b_out, 1);
            end else if (n == SPC - 2) begin
                check("after abort early", b_valid, 0);
            end
        end

        // Differential decode, continuous and stalled
        pat = '{1,1,0,0,1,0,1,1,0,0,0,0,0,0,0,0};
        run_stream("diff cont", pat, 8, 0, 0);
        run_stream("diff stall", pat, 8, 3, 0);
        for (int i = 0; i < 16; i++) pat[i] = 1'($urandom_range(1, 0));
        run_stream("rand cont", pat, 16, 0, 0);
        for (int i = 0; i < 16; i++) pat[i] = 1'($urandom_range(1, 0));
        run_stream("rand gap", pat, 10, $urandom_range(2, 1), 0);

        // Restart at sample 12 of window 3
        for (int i = 0; i < 16; i++) pat[i] = 1'($urandom_range(1, 0));
        run_stream("restart pre", pat, 3, 0, 12);
        fresh = 1'($urandom_range(1, 0));
        for (int n = 0; n < SPC; n++) begin
            drive(n == 0, 1'b1, act_smp(fresh), noise());
            if (n == SPC - 1) begin
                check("restart b_valid", b_valid, 1);
                check("restart b_out", b_out, fresh);
            end else begin
                check("restart no b_valid", b_valid, 0);
            end
        end

        // Reset mid-window at sample 10
        for (int n = 0; n < 10; n++) drive(n == 0, 1'b1, P7, Z0);
        resetn = 1'b0;
        drive(1'b0, 1'b1, P7, Z0);
        resetn = 1'b1;
        check("midreset ready", ready, 1);
        check("midreset b_out", b_out, 0);
        check("midreset b_valid", b_valid, 0);
        for (int n = 0; n < 2 * SPC; n++) begin
            drive(1'b0, 1'b1, P7, P7);
            check("post reset idle", b_valid, 0);
        end
        check("post reset ready", ready, 1);

        // Start without s_valid: counter stays at 0
        drive(1'b1, 1'b0, P7, P7);
        check("start novalid ready", ready, 0);
        for (int n = 0; n < SPC; n++) begin
            drive(1'b0, 1'b1, N7, noise());
            if (n == SPC - 1) begin
                check("novalid start b_valid", b_valid, 1);
                check("novalid start b_out", b_out, 0);
            end else begin
                check("novalid start early", b_valid, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
